// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multi-cycle control sequencer for the MIPS-subset datapath
module mc_control_fsm #(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [5:0]          Op,
  input  logic [5:0]          Func,
  input  logic                mem_ready,
  output logic                IRWrite,
  output logic                PCWrite,
  output logic                RegWrite,
  output logic                MemWrite,
  output logic [2:0]          RegDstSel,
  output logic [2:0]          ALUSrcSel,
  output logic [2:0]          toRegSel,
  output logic [2:0]          NPCOp,
  output logic [3:0]          ALUOp,
  output logic [2:0]          EXTOp,
  output logic [2:0]          state,
  output logic                illegal,
  output logic [RETIRE_W-1:0] retire_cnt
);

  // Sequencer states; the numeric values are visible on the state port.
  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;

  // Primary opcodes.
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes. The trapping and non-trapping add/sub encodings
  // both map to the wrapping datapath ops, since the datapath has no
  // overflow exception.
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_XOR   = 6'h26;

  // Datapath select encodings shared with the single-cycle control.
  localparam logic [2:0] RD_RT    = 3'b000;
  localparam logic [2:0] RD_RD    = 3'b001;
  localparam logic [2:0] RD_RA    = 3'b010;
  localparam logic [2:0] AS_RD2   = 3'b000;
  localparam logic [2:0] AS_EXT   = 3'b001;
  localparam logic [2:0] TR_ALU   = 3'b000;
  localparam logic [2:0] TR_MEM   = 3'b001;
  localparam logic [2:0] TR_EXT   = 3'b010;
  localparam logic [2:0] TR_PC4   = 3'b011;
  localparam logic [2:0] NPC_PC4  = 3'b000;
  localparam logic [2:0] NPC_BEQ  = 3'b001;
  localparam logic [2:0] NPC_JAL  = 3'b010;
  localparam logic [2:0] NPC_JR   = 3'b011;
  localparam logic [3:0] ALU_NONE = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [2:0] EXT_ZERO = 3'b000;
  localparam logic [2:0] EXT_SIGN = 3'b001;
  localparam logic [2:0] EXT_LUI  = 3'b010;

  logic [2:0]          state_q;
  logic [2:0]          state_d;
  logic [5:0]          op_q;
  logic [5:0]          func_q;
  logic [RETIRE_W-1:0] retire_q;

  logic is_addu;
  logic is_subu;
  logic is_xor;
  logic is_jr;
  logic is_ori;
  logic is_lui;
  logic is_lw;
  logic is_sw;
  logic is_beq;
  logic is_jal;
  logic is_legal;

  logic ir_write;
  logic pc_write;
  logic reg_write;
  logic mem_write;
  logic illegal_raw;
  logic retire;

  // Instruction class decode from the latched IR fields.
  always_comb begin
    is_addu  = (op_q == OP_RTYPE) && ((func_q == FN_ADDU) || (func_q == FN_ADD));
    is_subu  = (op_q == OP_RTYPE) && ((func_q == FN_SUBU) || (func_q == FN_SUB));
    is_xor   = (op_q == OP_RTYPE) && (func_q == FN_XOR);
    is_jr    = (op_q == OP_RTYPE) && (func_q == FN_JR);
    is_ori   = (op_q == OP_ORI);
    is_lui   = (op_q == OP_LUI);
    is_lw    = (op_q == OP_LW);
    is_sw    = (op_q == OP_SW);
    is_beq   = (op_q == OP_BEQ);
    is_jal   = (op_q == OP_JAL);
    is_legal = is_addu | is_subu | is_xor | is_jr | is_ori |
               is_lui | is_lw | is_sw | is_beq | is_jal;
  end

  // Datapath selects: held at zero during FETCH, otherwise decoded from the IR.
  always_comb begin
    RegDstSel = RD_RT;
    ALUSrcSel = AS_RD2;
    toRegSel  = TR_ALU;
    NPCOp     = NPC_PC4;
    ALUOp     = ALU_NONE;
    EXTOp     = EXT_ZERO;
    if (state_q != ST_FETCH) begin
      if (is_addu || is_subu || is_xor) RegDstSel = RD_RD;
      else if (is_jal)                  RegDstSel = RD_RA;

      if (is_ori || is_lw || is_sw) ALUSrcSel = AS_EXT;

      if (is_lw)       toRegSel = TR_MEM;
      else if (is_lui) toRegSel = TR_EXT;
      else if (is_jal) toRegSel = TR_PC4;

      if (is_beq)      NPCOp = NPC_BEQ;
      else if (is_jal) NPCOp = NPC_JAL;
      else if (is_jr)  NPCOp = NPC_JR;

      // beq compares by subtraction; the ALU zero flag drives the branch.
      if (is_addu || is_lw || is_sw) ALUOp = ALU_ADD;
      else if (is_subu || is_beq)    ALUOp = ALU_SUB;
      else if (is_ori)               ALUOp = ALU_OR;
      else if (is_xor)               ALUOp = ALU_XOR;

      if (is_lw || is_sw || is_beq) EXTOp = EXT_SIGN;
      else if (is_lui)              EXTOp = EXT_LUI;
    end
  end

  // Per-state write enables and next-state selection, before reset gating.
  always_comb begin
    state_d     = state_q;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    mem_write   = 1'b0;
    illegal_raw = 1'b0;
    case (state_q)
      ST_FETCH: begin
        ir_write = mem_ready;
        if (mem_ready) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (!is_legal) begin
          // Skip the offending word: advance PC to PC+4 without retiring.
          illegal_raw = 1'b1;
          pc_write    = 1'b1;
          state_d     = ST_FETCH;
        end else if (is_beq || is_jr) begin
          pc_write = 1'b1;
          state_d  = ST_FETCH;
        end else if (is_lw || is_sw) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        // Store request is held until memory acknowledges it.
        mem_write = is_sw;
        if (mem_ready) begin
          if (is_sw) begin
            pc_write = 1'b1;
            state_d  = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        state_d   = ST_FETCH;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // Reset forces every side effect off in the same cycle, aborting any
  // in-flight instruction without a partial write.
  always_comb begin
    IRWrite  = ir_write    & reset_n;
    PCWrite  = pc_write    & reset_n;
    RegWrite = reg_write   & reset_n;
    MemWrite = mem_write   & reset_n;
    illegal  = illegal_raw & reset_n;
    retire   = PCWrite & ~illegal_raw;
  end

  // State register, IR field latch and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_FETCH;
      op_q     <= 6'h00;
      func_q   <= 6'h00;
      retire_q <= '0;
    end else begin
      state_q <= state_d;
      if (IRWrite) begin
        op_q   <= Op;
        func_q <= Func;
      end
      if (retire) retire_q <= retire_q + RETIRE_W'(1);
    end
  end

  assign state      = state_q;
  assign retire_cnt = retire_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - scoreboard bench for mc_control_fsm
module tb_mc_control_fsm;

  localparam int RW = 3;

  // Select vectors: {RegDstSel, ALUSrcSel, toRegSel, NPCOp, ALUOp, EXTOp}
  localparam logic [18:0] SEL_NONE = 19'd0;
  localparam logic [18:0] SEL_ADDU = {3'b001, 3'b000, 3'b000, 3'b000, 4'b0010, 3'b000};
  localparam logic [18:0] SEL_SUBU = {3'b001, 3'b000, 3'b000, 3'b000, 4'b0011, 3'b000};
  localparam logic [18:0] SEL_XOR  = {3'b001, 3'b000, 3'b000, 3'b000, 4'b0101, 3'b000};
  localparam logic [18:0] SEL_ORI  = {3'b000, 3'b001, 3'b000, 3'b000, 4'b0001, 3'b000};
  localparam logic [18:0] SEL_LUI  = {3'b000, 3'b000, 3'b010, 3'b000, 4'b0000, 3'b010};
  localparam logic [18:0] SEL_LW   = {3'b000, 3'b001, 3'b001, 3'b000, 4'b0010, 3'b001};
  localparam logic [18:0] SEL_SW   = {3'b000, 3'b001, 3'b000, 3'b000, 4'b0010, 3'b001};
  localparam logic [18:0] SEL_BEQ  = {3'b000, 3'b000, 3'b000, 3'b001, 4'b0011, 3'b001};
  localparam logic [18:0] SEL_JAL  = {3'b010, 3'b000, 3'b011, 3'b010, 4'b0000, 3'b000};
  localparam logic [18:0] SEL_JR   = {3'b000, 3'b000, 3'b000, 3'b011, 4'b0000, 3'b000};

  localparam int K_WB = 0, K_BR = 1, K_LW = 2, K_SW = 3, K_ILL = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [5:0]    Op = 6'h00;
  logic [5:0]    Func = 6'h00;
  logic          mem_ready = 1'b0;
  logic          IRWrite, PCWrite, RegWrite, MemWrite;
  logic [2:0]    RegDstSel, ALUSrcSel, toRegSel, NPCOp, EXTOp, state;
  logic [3:0]    ALUOp;
  logic          illegal;
  logic [RW-1:0] retire_cnt;

  mc_control_fsm #(.RETIRE_W(RW)) dut (
    .clk(clk), .reset_n(reset_n), .Op(Op), .Func(Func), .mem_ready(mem_ready),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .RegDstSel(RegDstSel), .ALUSrcSel(ALUSrcSel), .toRegSel(toRegSel), .NPCOp(NPCOp),
    .ALUOp(ALUOp), .EXTOp(EXTOp), .state(state), .illegal(illegal), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [2:0]    st;
    logic [3:0]    en;
    logic          ill;
    logic [18:0]   sel;
    logic [RW-1:0] ret;
  } exp_t;

  exp_t          sb[$];
  int            compared = 0;
  int            mismatched = 0;
  logic [RW-1:0] exp_ret = '0;

  wire [18:0] sel_act = {RegDstSel, ALUSrcSel, toRegSel, NPCOp, ALUOp, EXTOp};
  wire [3:0]  en_act  = {IRWrite, PCWrite, RegWrite, MemWrite};

  // Monitor: one expected entry per driven cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      compared++;
      if (state !== e.st || en_act !== e.en || illegal !== e.ill ||
          sel_act !== e.sel || retire_cnt !== e.ret) begin
        mismatched++;
        $display("FAIL %s: got st=%0d en=%b ill=%b sel=%h ret=%0d, want st=%0d en=%b ill=%b sel=%h ret=%0d",
                 e.name, state, en_act, illegal, sel_act, retire_cnt,
                 e.st, e.en, e.ill, e.sel, e.ret);
      end
    end
  end

  // Drive one cycle of inputs and queue the expected outputs for that cycle.
  // en = {IRWrite, PCWrite, RegWrite, MemWrite}.
  task automatic step(input string name, input logic rst, input logic rdy,
                      input logic [5:0] op, input logic [5:0] fn,
                      input logic [2:0] st, input logic [3:0] en,
                      input logic ill, input logic [18:0] sel);
    exp_t e;
    @(posedge clk);
    #1;
    reset_n   = rst;
    mem_ready = rdy;
    Op        = op;
    Func      = fn;
    e.name = name; e.st = st; e.en = en; e.ill = ill; e.sel = sel; e.ret = exp_ret;
    sb.push_back(e);
    if (en[2] && !ill) exp_ret = exp_ret + 1'b1;
  endtask

  // One instruction; after FETCH the bus carries junk to prove the IR latch is used.
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input int kind, input logic [18:0] sel,
                           input int fw, input int mw);
    for (int i = 0; i < fw; i++)
      step({name, "_fwait"}, 1'b1, 1'b0, op, fn, 3'd0, 4'b0000, 1'b0, SEL_NONE);
    step({name, "_fetch"}, 1'b1, 1'b1, op, fn, 3'd0, 4'b1000, 1'b0, SEL_NONE);
    step({name, "_decode"}, 1'b1, 1'b0, 6'h2A, 6'h15, 3'd1, 4'b0000, 1'b0, sel);
    if (kind == K_BR)
      step({name, "_exec"}, 1'b1, 1'b1, 6'h2A, 6'h15, 3'd2, 4'b0100, 1'b0, sel);
    else if (kind == K_ILL)
      step({name, "_exec"}, 1'b1, 1'b1, 6'h2A, 6'h15, 3'd2, 4'b0100, 1'b1, SEL_NONE);
    else
      step({name, "_exec"}, 1'b1, 1'b1, 6'h2A, 6'h15, 3'd2, 4'b0000, 1'b0, sel);
    if (kind == K_LW || kind == K_SW) begin
      for (int i = 0; i < mw; i++)
        step({name, "_mwait"}, 1'b1, 1'b0, 6'h2A, 6'h15, 3'd3,
             (kind == K_SW) ? 4'b0001 : 4'b0000, 1'b0, sel);
      step({name, "_mem"}, 1'b1, 1'b1, 6'h2A, 6'h15, 3'd3,
           (kind == K_SW) ? 4'b0101 : 4'b0000, 1'b0, sel);
    end
    if (kind == K_WB || kind == K_LW)
      step({name, "_wb"}, 1'b1, 1'b1, 6'h2A, 6'h15, 3'd4, 4'b0110, 1'b0, sel);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    step("reset0", 1'b0, 1'b1, 6'h00, 6'h00, 3'd0, 4'b0000, 1'b0, SEL_NONE);
    step("reset1", 1'b0, 1'b1, 6'h3F, 6'h3F, 3'd0, 4'b0000, 1'b0, SEL_NONE);

    run_instr("addu", 6'h00, 6'h20, K_WB, SEL_ADDU, 0, 0);
    run_instr("subu", 6'h00, 6'h23, K_WB, SEL_SUBU, 1, 0);
    run_instr("xor",  6'h00, 6'h26, K_WB, SEL_XOR,  0, 0);
    run_instr("ori",  6'h0D, 6'h11, K_WB, SEL_ORI,  0, 0);
    run_instr("lui",  6'h0F, 6'h00, K_WB, SEL_LUI,  2, 0);
    run_instr("lw",   6'h23, 6'h00, K_LW, SEL_LW,   0, 3);
    run_instr("sw",   6'h2B, 6'h00, K_SW, SEL_SW,   0, 2);
    run_instr("beq",  6'h04, 6'h00, K_BR, SEL_BEQ,  0, 0);
    run_instr("jal",  6'h03, 6'h00, K_WB, SEL_JAL,  0, 0);
    run_instr("jr",   6'h00, 6'h08, K_BR, SEL_JR,   0, 0);
    run_instr("ill_op", 6'h3F, 6'h20, K_ILL, SEL_NONE, 0, 0);
    run_instr("ill_fn", 6'h00, 6'h00, K_ILL, SEL_NONE, 0, 0);
    run_instr("sw0",  6'h2B, 6'h00, K_SW, SEL_SW,   0, 0);

    // Reset during a store wait: no write that cycle, clean restart after.
    step("rst_sw_fetch",  1'b1, 1'b1, 6'h2B, 6'h00, 3'd0, 4'b1000, 1'b0, SEL_NONE);
    step("rst_sw_decode", 1'b1, 1'b0, 6'h2A, 6'h15, 3'd1, 4'b0000, 1'b0, SEL_SW);
    step("rst_sw_exec",   1'b1, 1'b1, 6'h2A, 6'h15, 3'd2, 4'b0000, 1'b0, SEL_SW);
    step("rst_sw_mwait",  1'b1, 1'b0, 6'h2A, 6'h15, 3'd3, 4'b0001, 1'b0, SEL_SW);
    step("rst_sw_abort",  1'b0, 1'b1, 6'h2A, 6'h15, 3'd3, 4'b0000, 1'b0, SEL_SW);
    exp_ret = '0;
    step("rst_after",     1'b1, 1'b0, 6'h00, 6'h20, 3'd0, 4'b0000, 1'b0, SEL_NONE);
    run_instr("addu2", 6'h00, 6'h21, K_WB, SEL_ADDU, 0, 0);
    step("idle_end", 1'b1, 1'b0, 6'h00, 6'h00, 3'd0, 4'b0000, 1'b0, SEL_NONE);

    @(posedge clk);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
